// File: rtl/video_raster_gen.sv
// video_raster_gen: raster timing, one-column-ahead VRAM prefetch,
// pixel serialiser and mono / 1-colour / 4-colour (MX) palette.
// Ports: clk_sys, reset_n (async, active low); ce_pix_p counter phase;
//   ce_pix_n data phase; mx, bw_mode mode requests (latched per frame);
//   rd_addr/rd_data VRAM read port ({column,row[7:0]}, {attr,bitmap});
//   R,G,B colour; hsync,vsync,hblank,vblank,de timing; frame_irq.
// Option VIDEO_LINEIRQ_EN adds line_cmp input and line_irq output.
module video_raster_gen #(
  parameter int H_TOTAL  = 512,
  parameter int H_ACTIVE = 384,
  parameter int HS_START = 416,
  parameter int HS_END   = 464,
  parameter int V_TOTAL  = 312,
  parameter int V_ACTIVE = 256,
  parameter int VS_START = 272,
  parameter int VS_END   = 282,
  parameter int ADDR_W   = 14
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_pix_p,
  input  logic              ce_pix_n,
  input  logic              mx,
  input  logic              bw_mode,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [2:0]        R,
  output logic [2:0]        G,
  output logic [2:0]        B,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              de,
  output logic              frame_irq
`ifdef VIDEO_LINEIRQ_EN
  ,
  output logic              line_irq,
  input  logic [8:0]        line_cmp
`endif
);

  localparam int HC_W = $clog2(H_TOTAL);
  localparam int VC_W = $clog2(V_TOTAL);
  localparam int CW   = ADDR_W - 8;

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HA_L    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_S    = HC_W'(HS_START);
  localparam logic [HC_W-1:0] HS_E    = HC_W'(HS_END);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VA_L    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_S    = VC_W'(VS_START);
  localparam logic [VC_W-1:0] VS_E    = VC_W'(VS_END);

  logic [HC_W-1:0] hc;
  logic [HC_W-1:0] hc_nx;
  logic [VC_W-1:0] vc;
  logic [VC_W-1:0] vc_nx;
  logic            hc_wrap;
  logic            frame_hit;

  logic [7:0] bmp;
  logic [7:0] bmp_nx;
  logic [7:0] attr;
  logic [7:0] attr_nx;
  logic       load;
  logic       hb_nx;
  logic       vb_nx;
  logic       blank_nx;
  logic       pix;

  logic       mx_l;
  logic       bw_l;
  logic [2:0] r_c;
  logic [2:0] g_c;
  logic [2:0] b_c;

  always_comb begin
    hc_wrap = (hc == HC_LAST);
    hc_nx   = hc_wrap ? '0 : hc + HC_W'(1);
    vc_nx   = vc;
    if (hc_wrap) begin
      vc_nx = (vc == VC_LAST) ? '0 : vc + VC_W'(1);
    end
    frame_hit = ce_pix_p & hc_wrap & (vc_nx == VA_L);
  end

  // Sync edges are decided on the counter value being entered, so
  // hsync/vsync always line up with the hc/vc they describe.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hc      <= '0;
      vc      <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      rd_addr <= '0;
    end else if (ce_pix_p) begin
      hc <= hc_nx;
      vc <= vc_nx;
      if (hc_nx == HS_S) begin
        hsync <= 1'b1;
      end else if (hc_nx == HS_E) begin
        hsync <= 1'b0;
      end
      if (hc_nx == HS_S && vc_nx == VS_S) begin
        vsync <= 1'b1;
      end else if (hc_nx == HS_S && vc_nx == VS_E) begin
        vsync <= 1'b0;
      end
      // Address the next column before its first pixel; at line
      // end this becomes column 0 of the following row.
      if (hc[2:0] == 3'd7) begin
        rd_addr <= {CW'(hc_nx >> 3), 8'(vc_nx)};
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_irq <= 1'b0;
      mx_l      <= 1'b0;
      bw_l      <= 1'b0;
    end else begin
      frame_irq <= frame_hit;
      if (frame_hit) begin
        mx_l <= mx;
        bw_l <= bw_mode;
      end
    end
  end

`ifdef VIDEO_LINEIRQ_EN
  logic line_hit;

  assign line_hit = ce_pix_p & hc_wrap &
                    (32'(vc_nx) == 32'(line_cmp));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= line_hit;
    end
  end
`endif

  always_comb begin
    load     = (hc[2:0] == 3'd0) & (hc < HA_L) & (vc < VA_L);
    bmp_nx   = load ? rd_data[7:0] : {bmp[6:0], 1'b0};
    attr_nx  = load ? rd_data[15:8] : attr;
    hb_nx    = (hc >= HA_L);
    vb_nx    = (vc >= VA_L);
    blank_nx = hb_nx | vb_nx;
    pix      = bmp_nx[7];
  end

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    unique case (1'b1)
      bw_l: begin
        r_c = {3{pix}};
        g_c = {3{pix}};
        b_c = {3{pix}};
      end
      (!bw_l && !mx_l): begin
        r_c = {3{pix & attr_nx[6]}};
        g_c = {3{pix & attr_nx[5]}};
        b_c = {3{pix & attr_nx[4]}};
      end
      (!bw_l && mx_l && pix): begin
        r_c = {attr_nx[6], attr_nx[7], attr_nx[6]};
        g_c = {attr_nx[5], attr_nx[7], attr_nx[5]};
        b_c = {attr_nx[4], attr_nx[7], attr_nx[4]};
      end
      (!bw_l && mx_l && !pix): begin
        r_c = {attr_nx[2], attr_nx[3], attr_nx[2]};
        g_c = {attr_nx[1], attr_nx[3], attr_nx[1]};
        b_c = {attr_nx[0], attr_nx[3], attr_nx[0]};
      end
      default: begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
      end
    endcase
  end

  // Colour is taken from the shifter value being written, so a word
  // loaded on this data phase is visible straight away.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bmp    <= '0;
      attr   <= '0;
      R      <= '0;
      G      <= '0;
      B      <= '0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      de     <= 1'b0;
    end else if (ce_pix_n) begin
      bmp    <= bmp_nx;
      attr   <= attr_nx;
      hblank <= hb_nx;
      vblank <= vb_nx;
      de     <= ~blank_nx;
      R      <= blank_nx ? 3'd0 : r_c;
      G      <= blank_nx ? 3'd0 : g_c;
      B      <= blank_nx ? 3'd0 : b_c;
    end
  end

endmodule

// File: tb/tb_video_raster_gen.sv
// tb_video_raster_gen: directed bench for video_raster_gen on a scaled
// 64x40 raster; every expectation is a hand-derived constant.
module tb_video_raster_gen;

  localparam int HT  = 64;
  localparam int HA  = 48;
  localparam int HSS = 52;
  localparam int HSE = 58;
  localparam int VT  = 40;
  localparam int VA  = 32;
  localparam int VSS = 34;
  localparam int VSE = 36;
  localparam int AW  = 14;
  localparam int FPX = HT * VT;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ce_pix_p;
  logic          ce_pix_n;
  logic          mx;
  logic          bw_mode;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [2:0]    R;
  logic [2:0]    G;
  logic [2:0]    B;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          de;
  logic          frame_irq;
`ifdef VIDEO_LINEIRQ_EN
  logic          line_irq;
  logic [8:0]    line_cmp;
`endif

  int   tests = 0;
  int   fails = 0;
  int   m_hc;
  int   m_vc;
  logic irq_f;
  logic irq_n;
  logic irq_l;

  video_raster_gen #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE),
    .ADDR_W(AW)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ce_pix_p(ce_pix_p),
    .ce_pix_n(ce_pix_n),
    .mx(mx),
    .bw_mode(bw_mode),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .R(R),
    .G(G),
    .B(B),
    .hsync(hsync),
    .vsync(vsync),
    .hblank(hblank),
    .vblank(vblank),
    .de(de),
    .frame_irq(frame_irq)
`ifdef VIDEO_LINEIRQ_EN
    ,
    .line_irq(line_irq),
    .line_cmp(line_cmp)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached got=running exp=done");
    $fatal(1, "watchdog");
  end

  task automatic step_n();
    ce_pix_n = 1'b1;
    @(negedge clk_sys);
    ce_pix_n = 1'b0;
    irq_n = frame_irq;
  endtask

  task automatic step_p();
    ce_pix_p = 1'b1;
    @(negedge clk_sys);
    ce_pix_p = 1'b0;
    irq_f = frame_irq;
`ifdef VIDEO_LINEIRQ_EN
    irq_l = line_irq;
`else
    irq_l = 1'b0;
`endif
    if (m_hc == HT - 1) begin
      m_hc = 0;
      m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
    end else begin
      m_hc = m_hc + 1;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    ce_pix_p = 1'b0;
    ce_pix_n = 1'b0;
    mx       = 1'b0;
    bw_mode  = 1'b0;
    rd_data  = 16'h0000;
`ifdef VIDEO_LINEIRQ_EN
    line_cmp = 9'd400;
`endif
    repeat (3) @(negedge clk_sys);
    tests++;
    if ({R, G, B} !== 9'h000) begin
      fails++;
      $display("FAIL reset_rgb got=%h exp=000", {R, G, B});
    end
    tests++;
    if ({hsync, vsync, hblank, vblank, de, frame_irq} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=000000",
               {hsync, vsync, hblank, vblank, de, frame_irq});
    end
    tests++;
    if (rd_addr !== 14'h0000) begin
      fails++;
      $display("FAIL reset_addr got=%h exp=0000", rd_addr);
    end
    reset_n = 1'b1;
    m_hc = 0;
    m_vc = 0;
  endtask

  task automatic test_timing();
    logic          eb;
    logic          ev;
    logic          hs_e;
    logic          vs_e;
    logic          irq_e;
    logic [AW-1:0] exp_addr;
    int            lin;
    int            prev_hc;
    int            n_firq;
    exp_addr = '0;
    n_firq   = 0;
    rd_data  = 16'h0000;
    for (int i = 0; i < 2 * FPX; i++) begin
      step_n();
      eb = (m_hc >= HA);
      ev = (m_vc >= VA);
      tests++;
      if ({hblank, vblank, de} !== {eb, ev, ~(eb | ev)}) begin
        fails++;
        $display("FAIL timing_blank hc=%0d vc=%0d got=%b exp=%b",
                 m_hc, m_vc, {hblank, vblank, de}, {eb, ev, ~(eb | ev)});
      end
      tests++;
      if (irq_n !== 1'b0) begin
        fails++;
        $display("FAIL irq_width hc=%0d vc=%0d got=%b exp=0",
                 m_hc, m_vc, irq_n);
      end
      prev_hc = m_hc;
      step_p();
      if (prev_hc % 8 == 7) begin
        exp_addr = {6'(m_hc >> 3), 8'(m_vc)};
      end
      lin   = m_vc * HT + m_hc;
      hs_e  = (m_hc >= HSS) && (m_hc < HSE);
      vs_e  = (lin >= VSS * HT + HSS) && (lin < VSE * HT + HSS);
      irq_e = (m_hc == 0) && (m_vc == VA);
      n_firq += int'(irq_f);
      tests++;
      if ({hsync, vsync} !== {hs_e, vs_e}) begin
        fails++;
        $display("FAIL timing_sync hc=%0d vc=%0d got=%b exp=%b",
                 m_hc, m_vc, {hsync, vsync}, {hs_e, vs_e});
      end
      tests++;
      if (irq_f !== irq_e) begin
        fails++;
        $display("FAIL frame_irq hc=%0d vc=%0d got=%b exp=%b",
                 m_hc, m_vc, irq_f, irq_e);
      end
      tests++;
      if (rd_addr !== exp_addr) begin
        fails++;
        $display("FAIL fetch_addr hc=%0d vc=%0d got=%h exp=%h",
                 m_hc, m_vc, rd_addr, exp_addr);
      end
    end
    tests++;
    if (n_firq !== 2) begin
      fails++;
      $display("FAIL frame_irq_count got=%0d exp=2", n_firq);
    end
  endtask

  task automatic test_pixels();
    logic [8:0] exp_c;
    rd_data = 16'h70FF;
    for (int i = 0; i < FPX; i++) begin
      step_n();
      exp_c = (m_hc < HA && m_vc < VA) ? 9'h1FF : 9'h000;
      tests++;
      if ({R, G, B} !== exp_c) begin
        fails++;
        $display("FAIL pix_70ff hc=%0d vc=%0d got=%h exp=%h",
                 m_hc, m_vc, {R, G, B}, exp_c);
      end
      step_p();
    end
  endtask

  task automatic test_bw_latch();
    logic [8:0] exp_c;
    logic       act;
    rd_data = 16'h0F0F;
    mx      = 1'b0;
    bw_mode = 1'b0;
    for (int i = 0; i < FPX; i++) begin
      if (m_hc == 0 && m_vc == VA / 2) bw_mode = 1'b1;
      step_n();
      tests++;
      if ({R, G, B} !== 9'h000) begin
        fails++;
        $display("FAIL bw_hold hc=%0d vc=%0d got=%h exp=000",
                 m_hc, m_vc, {R, G, B});
      end
      step_p();
    end
    for (int i = 0; i < FPX; i++) begin
      step_n();
      act   = (m_hc < HA) && (m_vc < VA);
      exp_c = (act && (m_hc % 8) >= 4) ? 9'h1FF : 9'h000;
      tests++;
      if ({R, G, B} !== exp_c) begin
        fails++;
        $display("FAIL bw_mono hc=%0d vc=%0d got=%h exp=%h",
                 m_hc, m_vc, {R, G, B}, exp_c);
      end
      step_p();
    end
  endtask

  task automatic test_mx_latch();
    logic [8:0] exp_c;
    logic       act;
    logic       even;
    rd_data = 16'hC3AA;
    mx      = 1'b1;
    bw_mode = 1'b0;
    for (int i = 0; i < FPX; i++) begin
      step_n();
      act   = (m_hc < HA) && (m_vc < VA);
      even  = (m_hc % 2) == 0;
      exp_c = (act && even) ? 9'h1FF : 9'h000;
      tests++;
      if ({R, G, B} !== exp_c) begin
        fails++;
        $display("FAIL mx_hold hc=%0d vc=%0d got=%h exp=%h",
                 m_hc, m_vc, {R, G, B}, exp_c);
      end
      step_p();
    end
    for (int i = 0; i < FPX; i++) begin
      step_n();
      act  = (m_hc < HA) && (m_vc < VA);
      even = (m_hc % 2) == 0;
      if (!act) exp_c = 9'h000;
      else if (even) exp_c = {3'd7, 3'd2, 3'd2};
      else exp_c = {3'd0, 3'd5, 3'd5};
      tests++;
      if ({R, G, B} !== exp_c) begin
        fails++;
        $display("FAIL mx_colour hc=%0d vc=%0d got=%h exp=%h",
                 m_hc, m_vc, {R, G, B}, exp_c);
      end
      step_p();
    end
  endtask

`ifdef VIDEO_LINEIRQ_EN
  task automatic test_line_irq();
    int   n_l;
    logic exp_l;
    line_cmp = 9'd16;
    n_l = 0;
    for (int i = 0; i < FPX; i++) begin
      step_n();
      step_p();
      n_l += int'(irq_l);
      exp_l = (m_hc == 0) && (m_vc == 16);
      tests++;
      if (irq_l !== exp_l) begin
        fails++;
        $display("FAIL line_irq_pos hc=%0d vc=%0d got=%b exp=%b",
                 m_hc, m_vc, irq_l, exp_l);
      end
    end
    tests++;
    if (n_l !== 1) begin
      fails++;
      $display("FAIL line_irq_count got=%0d exp=1", n_l);
    end
    line_cmp = 9'd400;
    n_l = 0;
    for (int i = 0; i < FPX; i++) begin
      step_n();
      step_p();
      n_l += int'(irq_l);
    end
    tests++;
    if (n_l !== 0) begin
      fails++;
      $display("FAIL line_irq_none got=%0d exp=0", n_l);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [AW-1:0] exp_a;
    rd_data = 16'h70FF;
    for (int i = 0; i < 5 * HT + 20; i++) begin
      step_n();
      step_p();
    end
    tests++;
    if ({R, G, B} !== {3'd5, 3'd5, 3'd5}) begin
      fails++;
      $display("FAIL pre_reset_mx got=%h exp=%h",
               {R, G, B}, {3'd5, 3'd5, 3'd5});
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({R, G, B} !== 9'h000) begin
      fails++;
      $display("FAIL midreset_rgb got=%h exp=000", {R, G, B});
    end
    tests++;
    if ({hsync, vsync, hblank, vblank, de, frame_irq} !== 6'b0) begin
      fails++;
      $display("FAIL midreset_flags got=%b exp=000000",
               {hsync, vsync, hblank, vblank, de, frame_irq});
    end
    tests++;
    if (rd_addr !== 14'h0000) begin
      fails++;
      $display("FAIL midreset_addr got=%h exp=0000", rd_addr);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    m_hc = 0;
    m_vc = 0;
    for (int i = 0; i < 8; i++) begin
      step_n();
      tests++;
      if ({R, G, B} !== 9'h1FF) begin
        fails++;
        $display("FAIL restart_pix hc=%0d got=%h exp=1ff",
                 m_hc, {R, G, B});
      end
      step_p();
      exp_a = (m_hc == 8) ? 14'h0100 : 14'h0000;
      tests++;
      if (rd_addr !== exp_a) begin
        fails++;
        $display("FAIL restart_addr hc=%0d got=%h exp=%h",
                 m_hc, rd_addr, exp_a);
      end
    end
  endtask

  initial begin
    irq_f = 1'b0;
    irq_n = 1'b0;
    irq_l = 1'b0;
    test_reset();
    test_timing();
    test_pixels();
    test_bw_latch();
    test_mx_latch();
`ifdef VIDEO_LINEIRQ_EN
    test_line_irq();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
